adc_spi_timing: RTL and testbench

//   Generates SCLK and CS for the serial ADC capture path from the system clock.

---
 rtl/adc_spi_pkg.sv | 15 +
 rtl/adc_spi_timing_sclk_divider.sv | 31 +++
 rtl/adc_spi_timing.sv | 183 ++++++++++++++++++
 tb/tb_adc_spi_timing.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared definitions for the serial ADC capture path: FSM state encoding and
// frame/data widths also used by the downstream receiver.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } adc_state_t;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;

endpackage

// File: rtl/adc_spi_timing_sclk_divider.sv
// SCLK half-period divider: counts clk cycles and emits a one-cycle half_tick
// every HALF_DIV clocks; a synchronous clear restarts the count at zero.
module sclk_divider #(
  parameter int HALF_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_half_tick
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Decoded from the registered count only, so the FSM can use it to pick
  // its next state (which in turn drives i_clr) without a combinational loop.
  assign o_half_tick = (r_cnt == LAST);

endmodule

// File: rtl/adc_spi_timing.sv
// SCLK / CS generator for the serial ADC: one NBITS-bit frame per launch request.
// Build option ADC_TRIGGER_EN replaces the free-running period counter with a trig input.
//
// Handshake note: there is no valid/ready pair here; a launch request is a
// single-cycle strobe that is accepted only in IDLE and otherwise dropped
// with a one-cycle overrun pulse.
module adc_spi_timing
  import adc_spi_pkg::*;
#(
  parameter int HALF_DIV      = 4,
  parameter int NBITS         = ADC_FRAME_BITS,
  parameter int QUIET_CYC     = 8,
  parameter int SAMPLE_PERIOD = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
`ifdef ADC_TRIGGER_EN
  input  logic       trig,
`endif
  output logic       SCLK,
  output logic       CS,
  output logic       frame_start,
  output logic       frame_end,
  output logic       busy,
  output logic [4:0] bit_cnt,
  output logic       overrun,
  output adc_state_t o_dbg_state
);

  localparam logic [4:0] NB5 = 5'(NBITS);
  localparam int QW = $clog2(QUIET_CYC + 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYC - 1);

  adc_state_t    r_state;
  adc_state_t    w_state_nxt;
  logic          r_cs;
  logic          r_sclk;
  logic [4:0]    r_bit_cnt;
  logic          r_fs;
  logic          r_fe;
  logic          r_busy;
  logic          r_ovr;
  logic [QW-1:0] r_quiet;

  logic          w_cs_nxt;
  logic          w_sclk_nxt;
  logic [4:0]    w_bit_nxt;
  logic          w_fs_nxt;
  logic          w_fe_nxt;
  logic          w_ovr_nxt;
  logic [QW-1:0] w_quiet_nxt;
  logic          w_launch;
  logic          w_half_tick;
  logic          w_div_clr;

`ifdef ADC_TRIGGER_EN
  assign w_launch = enable && trig;
`else
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);

  logic [PW-1:0] r_period;

  // Cleared while disabled so the first launch lands a full period after enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period <= '0;
    end else if (!enable || (r_period == PERIOD_LAST)) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + 1'b1;
    end
  end

  assign w_launch = enable && (r_period == PERIOD_LAST);
`endif

  // Restarting on every state entry keeps edge spacing exact from SETUP onward.
  assign w_div_clr = (w_state_nxt != r_state) || (r_state == IDLE);

  sclk_divider #(
    .HALF_DIV (HALF_DIV)
  ) u_div (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_clr       (w_div_clr),
    .o_half_tick (w_half_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cs_nxt    = r_cs;
    w_sclk_nxt  = r_sclk;
    w_bit_nxt   = r_bit_cnt;
    w_fs_nxt    = 1'b0;
    w_fe_nxt    = 1'b0;
    w_ovr_nxt   = w_launch && (r_state != IDLE);
    w_quiet_nxt = '0;
    case (r_state)
      IDLE: begin
        w_cs_nxt   = 1'b1;
        w_sclk_nxt = 1'b1;
        if (w_launch) begin
          w_state_nxt = SETUP;
          w_cs_nxt    = 1'b0;
          w_fs_nxt    = 1'b1;
          w_bit_nxt   = '0;
        end
      end
      SETUP: begin
        if (w_half_tick) begin
          w_state_nxt = SHIFT;
          w_sclk_nxt  = 1'b0;
          w_bit_nxt   = r_bit_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (w_half_tick) begin
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else if (r_bit_cnt == NB5) begin
            // Last rising edge has been held a full half period: close the frame.
            w_state_nxt = QUIET;
            w_cs_nxt    = 1'b1;
            w_fe_nxt    = 1'b1;
          end else begin
            w_sclk_nxt = 1'b0;
            w_bit_nxt  = r_bit_cnt + 1'b1;
          end
        end
      end
      QUIET: begin
        w_cs_nxt   = 1'b1;
        w_sclk_nxt = 1'b1;
        if (r_quiet == QUIET_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_quiet_nxt = r_quiet + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cs_nxt    = 1'b1;
        w_sclk_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cs      <= 1'b1;
      r_sclk    <= 1'b1;
      r_bit_cnt <= '0;
      r_fs      <= 1'b0;
      r_fe      <= 1'b0;
      r_busy    <= 1'b0;
      r_ovr     <= 1'b0;
      r_quiet   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cs      <= w_cs_nxt;
      r_sclk    <= w_sclk_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_fs      <= w_fs_nxt;
      r_fe      <= w_fe_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_ovr     <= w_ovr_nxt;
      r_quiet   <= w_quiet_nxt;
    end
  end

  assign SCLK        = r_sclk;
  assign CS          = r_cs;
  assign frame_start = r_fs;
  assign frame_end   = r_fe;
  assign busy        = r_busy;
  assign bit_cnt     = r_bit_cnt;
  assign overrun     = r_ovr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_adc_spi_timing.sv
// Directed bench for adc_spi_timing at default parameters; covers the trig
// build when ADC_TRIGGER_EN is defined.
module tb_adc_spi_timing;
  import adc_spi_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
`ifdef ADC_TRIGGER_EN
  logic       trig = 1'b0;
`endif
  logic       SCLK, CS, frame_start, frame_end, busy, overrun;
  logic [4:0] bit_cnt;
  adc_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic ovr_seen = 1'b0;

  adc_spi_timing dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
`ifdef ADC_TRIGGER_EN
    .trig        (trig),
`endif
    .SCLK        (SCLK),
    .CS          (CS),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .busy        (busy),
    .bit_cnt     (bit_cnt),
    .overrun     (overrun),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  always @(negedge clk) if (overrun === 1'b1) ovr_seen = 1'b1;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < 2000);
  endtask

  // Entered on the frame_start cycle; walks the frame up to the CS rise.
  task automatic run_frame(input string tag);
    int t, falls, rises, fall_err, rise_err, bc_err;
    logic prev;
    logic [15:0] pat, rx;
    pat = 16'h0ABC;
    rx = '0;
    t = 0; falls = 0; rises = 0; fall_err = 0; rise_err = 0; bc_err = 0;
    chk({tag, "_fs_cs"}, {31'd0, CS}, 32'd0);
    chk({tag, "_fs_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_fs_bitcnt"}, {27'd0, bit_cnt}, 32'd0);
    prev = SCLK;
    while (CS === 1'b0 && t < 400) begin
      step();
      t++;
      if (prev && !SCLK) begin
        if (t != 4 + 8 * falls) fall_err++;
        falls++;
        if (bit_cnt != 5'(falls)) bc_err++;
      end
      if (!prev && SCLK) begin
        if (t != 8 + 8 * rises) rise_err++;
        rx = {rx[14:0], pat[15 - rises]};
        rises++;
      end
      prev = SCLK;
    end
    chk({tag, "_cs_low_len"}, t, 32'd132);
    chk({tag, "_sclk_falls"}, falls, 32'd16);
    chk({tag, "_fall_timing"}, fall_err, 32'd0);
    chk({tag, "_rise_timing"}, rise_err, 32'd0);
    chk({tag, "_bitcnt_track"}, bc_err, 32'd0);
    chk({tag, "_frame_end"}, {31'd0, frame_end}, 32'd1);
    chk({tag, "_end_bitcnt"}, {27'd0, bit_cnt}, 32'd16);
    chk({tag, "_rx_data"}, {20'd0, rx[11:0]}, 32'h0ABC);
  endtask

  initial begin
    int n, fs_cyc, t, cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", {31'd0, CS}, 32'd1);
    chk("rst_sclk", {31'd0, SCLK}, 32'd1);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    chk("rst_fe", {31'd0, frame_end}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bitcnt", {27'd0, bit_cnt}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b1;
    step();

`ifdef ADC_TRIGGER_EN
    enable = 1'b1;
    cyc = 0;
    while (cyc < 10) step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("trig_fs", {31'd0, frame_start}, 32'd1);
    chk("trig_cs", {31'd0, CS}, 32'd0);
    t = 0;
    while (t < 39) begin step(); t++; end
    trig = 1'b1;
    step();
    t++;
    trig = 1'b0;
    chk("trig_ovr", {31'd0, overrun}, 32'd1);
    chk("trig_ovr_cs", {31'd0, CS}, 32'd0);
    chk("trig_ovr_nofs", {31'd0, frame_start}, 32'd0);
    step();
    t++;
    chk("trig_ovr_pulse", {31'd0, overrun}, 32'd0);
    while (CS === 1'b0 && t < 400) begin step(); t++; end
    chk("trig_cs_len", t, 32'd132);
    chk("trig_fe", {31'd0, frame_end}, 32'd1);
    chk("trig_bitcnt", {27'd0, bit_cnt}, 32'd16);
    cnt = 0;
    repeat (300) begin step(); if (frame_start) cnt++; end
    chk("trig_no_extra", cnt, 32'd0);
    enable = 1'b0;
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("trig_gated_fs", {31'd0, frame_start}, 32'd0);
    step();
    chk("trig_gated_busy", {31'd0, busy}, 32'd0);
`else
    // first frame after enable
    enable = 1'b1;
    wait_fs(n);
    chk("t1_first_fs", n, 32'd256);
    fs_cyc = cyc;
    run_frame("t1");
    chk("t1_fe_time", cyc - fs_cyc + n, 32'd388);

    // continuous run: four more frames at fixed spacing
    repeat (4) exp_q.push_back(32'd256);
    for (int i = 0; i < 4; i++) begin
      repeat (20) step();
      chk("t2_quiet_busy", {31'd0, busy}, 32'd0);
      chk("t2_hold_bitcnt", {27'd0, bit_cnt}, 32'd16);
      chk("t2_idle_lines", {30'd0, CS, SCLK}, 32'd3);
      wait_fs(n);
      chk("t2_spacing", cyc - fs_cyc, exp_q.pop_front());
      fs_cyc = cyc;
      run_frame("t2");
    end

    // enable dropped mid-frame
    wait_fs(n);
    t = 0;
    while (bit_cnt != 5'd7 && t < 200) begin step(); t++; end
    chk("t3_reach7", {27'd0, bit_cnt}, 32'd7);
    enable = 1'b0;
    t = 0;
    while (CS === 1'b0 && t < 300) begin step(); t++; end
    chk("t3_end_bitcnt", {27'd0, bit_cnt}, 32'd16);
    chk("t3_fe", {31'd0, frame_end}, 32'd1);
    cnt = 0;
    repeat (1000) begin step(); if (frame_start) cnt++; end
    chk("t3_no_launch", cnt, 32'd0);
    chk("t3_idle_busy", {31'd0, busy}, 32'd0);

    // async reset mid-frame
    enable = 1'b1;
    wait_fs(n);
    chk("t4_first_fs", n, 32'd256);
    t = 0;
    while (bit_cnt != 5'd9 && t < 200) begin step(); t++; end
    chk("t4_reach9", {27'd0, bit_cnt}, 32'd9);
    reset = 1'b0;
    #1;
    chk("t4_rst_cs", {31'd0, CS}, 32'd1);
    chk("t4_rst_sclk", {31'd0, SCLK}, 32'd1);
    chk("t4_rst_busy", {31'd0, busy}, 32'd0);
    chk("t4_rst_bitcnt", {27'd0, bit_cnt}, 32'd0);
    enable = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    enable = 1'b1;
    wait_fs(n);
    chk("t4_relaunch", n, 32'd256);
    run_frame("t4");
    chk("no_overrun", {31'd0, ovr_seen}, 32'd0);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
